// File: rtl/cam_pkg.sv
// Shared definitions for the camera power-up / reset sequencer.
package cam_pkg;

    // Sequencer states; encodings are visible on the debug probe.
    typedef enum logic [2:0] {
        S_PWDN = 3'd0,
        S_RST  = 3'd1,
        S_BOOT = 3'd2,
        S_CFG  = 3'd3,
        S_CFGW = 3'd4,
        S_SYNC = 3'd5,
        S_RUN  = 3'd6,
        S_FAIL = 3'd7
    } cam_state_t;

    // Default timings for OV-class sensors at a 24 MHz-class pixclk.
    localparam int DEF_T_PWDN      = 65536;
    localparam int DEF_T_RST       = 32768;
    localparam int DEF_T_BOOT      = 131072;
    localparam int DEF_T_CFG_TO    = 4194304;
    localparam int DEF_FRAMES_SKIP = 2;
    localparam int DEF_MAX_RETRY   = 3;

    localparam int RETRY_W = 2;

    // Registered pin/status levels, decoded from the state.
    typedef struct packed {
        logic pwdn;
        logic rst_n;
        logic start;
        logic temp_reset;
        logic ready;
        logic fail;
    } cam_pins_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Moore output decode: pin levels belong to the state alone.
    function automatic cam_pins_t state_pins(input cam_state_t s);
        cam_pins_t p;
        p = '{pwdn: 1'b0, rst_n: 1'b1, start: 1'b0, temp_reset: 1'b1, ready: 1'b0, fail: 1'b0};
        case (s)
            S_PWDN: begin p.pwdn = 1'b1; p.rst_n = 1'b0; end
            S_RST:  p.rst_n = 1'b0;
            S_CFG:  p.start = 1'b1;
            S_RUN:  begin p.temp_reset = 1'b0; p.ready = 1'b1; end
            S_FAIL: begin p.pwdn = 1'b1; p.rst_n = 1'b0; p.fail = 1'b1; end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module seq_timer #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Load takes precedence; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/cam_reset_sequencer.sv
// Camera power-up sequencer: PWDN/RESET pins, config launch with retries,
// and frame-aligned release of the pixel pipeline reset.
import cam_pkg::*;

module cam_reset_sequencer #(
    parameter int T_PWDN      = DEF_T_PWDN,
    parameter int T_RST       = DEF_T_RST,
    parameter int T_BOOT      = DEF_T_BOOT,
    parameter int T_CFG_TO    = DEF_T_CFG_TO,
    parameter int FRAMES_SKIP = DEF_FRAMES_SKIP,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic               pixclk,
    input  logic               rst_n,
    input  logic               restart,
    input  logic               cfg_done,
    input  logic               cfg_err,
    input  logic               cam_vsync,
    output logic               cam_pwdn,
    output logic               cam_rst_n,
    output logic               cfg_start,
    output logic               temp_reset,
    output logic               ready,
    output logic               cfg_fail,
    output logic [2:0]         state_o,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int T_MAX = max_int(max_int(T_PWDN, T_RST), max_int(T_BOOT, T_CFG_TO));
    localparam int TW    = $clog2(T_MAX) + 1;
    localparam int EW    = $clog2(FRAMES_SKIP + 2);

    // Timer counts down to zero, so a state lasting T cycles loads T-1.
    localparam logic [TW-1:0]      LD_PWDN = TW'(T_PWDN - 1);
    localparam logic [TW-1:0]      LD_RST  = TW'(T_RST - 1);
    localparam logic [TW-1:0]      LD_BOOT = TW'(T_BOOT - 1);
    localparam logic [TW-1:0]      LD_CFGW = TW'(T_CFG_TO - 1);
    localparam logic [EW-1:0]      SKIP_L  = EW'(FRAMES_SKIP);
    localparam logic [RETRY_W-1:0] MAXR_L  = RETRY_W'(MAX_RETRY);

    cam_state_t         state, state_nxt;
    cam_pins_t          pins_q, pins_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic [EW-1:0]      edge_cnt, edge_cnt_nxt;
    logic               vsync_q, vs_rise;
    logic               tmr_load, tmr_exp;
    logic [TW-1:0]      tmr_val;

    seq_timer #(.W(TW), .RST_VAL(LD_PWDN)) u_timer (
        .clk      (pixclk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    // Previous vsync for rising-edge detection.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) vsync_q <= 1'b0;
        else        vsync_q <= cam_vsync;
    end

    // State, counters and registered outputs.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PWDN;
            pins_q    <= state_pins(S_PWDN);
            retry_cnt <= '0;
            edge_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            pins_q    <= pins_nxt;
            retry_cnt <= retry_nxt;
            edge_cnt  <= edge_cnt_nxt;
        end
    end

    // Next-state decision; restart overrides everything, error beats done.
    always_comb begin
        state_nxt    = state;
        retry_nxt    = retry_cnt;
        edge_cnt_nxt = edge_cnt;
        vs_rise      = cam_vsync & ~vsync_q;
        case (state)
            S_PWDN: if (tmr_exp) state_nxt = S_RST;
            S_RST:  if (tmr_exp) state_nxt = S_BOOT;
            S_BOOT: if (tmr_exp) state_nxt = S_CFG;
            S_CFG:  state_nxt = S_CFGW;
            S_CFGW: begin
                if (cfg_err || (tmr_exp && !cfg_done)) begin
                    if (retry_cnt < MAXR_L) begin
                        retry_nxt = retry_cnt + 1'b1;
                        state_nxt = S_PWDN;
                    end else begin
                        state_nxt = S_FAIL;
                    end
                end else if (cfg_done) begin
                    state_nxt    = S_SYNC;
                    edge_cnt_nxt = '0;
                end
            end
            S_SYNC: begin
                if (vs_rise) begin
                    if (edge_cnt == SKIP_L) state_nxt    = S_RUN;
                    else                    edge_cnt_nxt = edge_cnt + 1'b1;
                end
            end
            default: ;
        endcase
        if (restart) begin
            state_nxt = S_PWDN;
            retry_nxt = '0;
        end
        tmr_load = restart || (state_nxt != state);
        case (state_nxt)
            S_PWDN:  tmr_val = LD_PWDN;
            S_RST:   tmr_val = LD_RST;
            S_BOOT:  tmr_val = LD_BOOT;
            S_CFGW:  tmr_val = LD_CFGW;
            default: tmr_val = '0;
        endcase
        pins_nxt = state_pins(state_nxt);
    end

    assign cam_pwdn   = pins_q.pwdn;
    assign cam_rst_n  = pins_q.rst_n;
    assign cfg_start  = pins_q.start;
    assign temp_reset = pins_q.temp_reset;
    assign ready      = pins_q.ready;
    assign cfg_fail   = pins_q.fail;
    assign state_o    = state;

endmodule

// File: tb/tb_cam_reset_sequencer.sv
// Directed bench for cam_reset_sequencer with an expected-snapshot queue.
module tb_cam_reset_sequencer;

    logic       pixclk = 1'b0;
    logic       rst_n = 1'b0, restart = 1'b0, cfg_done = 1'b0, cfg_err = 1'b0, cam_vsync = 1'b0;
    logic       cam_pwdn, cam_rst_n, cfg_start, temp_reset, ready, cfg_fail;
    logic [2:0] state_o;
    logic [1:0] retry_cnt;

    int total = 0;
    int bad   = 0;

    string       tag_q[$];
    logic [10:0] exp_q[$];

    wire [10:0] obs = {state_o, cam_pwdn, cam_rst_n, cfg_start, temp_reset, ready, cfg_fail, retry_cnt};

    cam_reset_sequencer #(
        .T_PWDN(4), .T_RST(3), .T_BOOT(5), .T_CFG_TO(20), .FRAMES_SKIP(2), .MAX_RETRY(1)
    ) dut (
        .pixclk(pixclk), .rst_n(rst_n), .restart(restart), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .cam_vsync(cam_vsync), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
        .cfg_start(cfg_start), .temp_reset(temp_reset), .ready(ready), .cfg_fail(cfg_fail),
        .state_o(state_o), .retry_cnt(retry_cnt)
    );

    always #5 pixclk = ~pixclk;

    // Expected snapshot {state, pwdn, rst_n, start, temp_reset, ready, fail, retry}.
    function automatic logic [10:0] sv(input int st, input int rc);
        logic [5:0] p;
        case (st)
            0:       p = 6'b100100;
            1:       p = 6'b000100;
            2:       p = 6'b010100;
            3:       p = 6'b011100;
            4, 5:    p = 6'b010100;
            6:       p = 6'b010010;
            default: p = 6'b100101;
        endcase
        return {3'(st), p, 2'(rc)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge pixclk);
        #1;
    endtask

    task automatic push(input string t, input logic [10:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic pop_check();
        string       t;
        logic [10:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL sb_underflow: observed=%b required=queued entry", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%b required=%b", t, obs, e);
            end
        end
    endtask

    task automatic chk(input int n, input string t, input int st, input int rc);
        push(t, sv(st, rc));
        tick(n);
        pop_check();
    endtask

    // From the first cycle of PWDN through to the first cycle of CFGW.
    task automatic seq_to_cfgw(input int rc);
        chk(3, "pwdn_hold", 0, rc);
        chk(1, "rst_entry", 1, rc);
        chk(2, "rst_hold", 1, rc);
        chk(1, "boot_entry", 2, rc);
        chk(4, "boot_hold", 2, rc);
        chk(1, "cfg_start", 3, rc);
        chk(1, "cfgw_entry", 4, rc);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        push("restart", sv(0, 0));
        tick(1);
        restart = 1'b0;
        pop_check();
    endtask

    task automatic vs_pulse(input int gap, input string t, input int st, input int rc);
        cam_vsync = 1'b1;
        chk(1, t, st, rc);
        cam_vsync = 1'b0;
        tick(gap);
    endtask

    task automatic done_to_sync(input int rc);
        cfg_done = 1'b1;
        chk(1, "sync_entry", 5, rc);
        cfg_done = 1'b0;
    endtask

    initial begin
        // Reset state
        chk(3, "reset_state", 0, 0);
        rst_n = 1'b1;

        // Nominal
        seq_to_cfgw(0);
        chk(5, "cfgw_wait", 4, 0);
        done_to_sync(0);
        for (int i = 0; i < 3; i++)
            vs_pulse(29, (i < 2) ? "sync_skip" : "run_release", (i < 2) ? 5 : 6, 0);
        chk(1, "run_hold", 6, 0);

        // Error then success
        do_restart();
        seq_to_cfgw(0);
        chk(2, "cfgw_wait", 4, 0);
        cfg_err = 1'b1;
        chk(1, "err_retry", 0, 1);
        cfg_err = 1'b0;
        seq_to_cfgw(1);
        chk(2, "cfgw_wait2", 4, 1);
        done_to_sync(1);
        for (int i = 0; i < 3; i++)
            vs_pulse(5, (i < 2) ? "sync_skip2" : "run_release2", (i < 2) ? 5 : 6, 1);

        // Timeout exhaustion
        do_restart();
        seq_to_cfgw(0);
        chk(19, "cfgw_last", 4, 0);
        chk(1, "timeout_retry", 0, 1);
        seq_to_cfgw(1);
        chk(19, "cfgw_last2", 4, 1);
        chk(1, "timeout_fail", 7, 1);
        chk(10, "fail_hold", 7, 1);
        do_restart();

        // Done and error together, then restart beating done
        seq_to_cfgw(0);
        cfg_done = 1'b1;
        cfg_err  = 1'b1;
        chk(1, "done_err", 0, 1);
        cfg_done = 1'b0;
        cfg_err  = 1'b0;
        seq_to_cfgw(1);
        chk(3, "cfgw_wait3", 4, 1);
        cfg_done = 1'b1;
        do_restart();
        cfg_done = 1'b0;
        seq_to_cfgw(0);

        // vsync already high at SYNC entry
        cam_vsync = 1'b1;
        chk(2, "cfgw_vs_high", 4, 0);
        done_to_sync(0);
        chk(5, "sync_vs_held", 5, 0);
        cam_vsync = 1'b0;
        chk(3, "sync_vs_low", 5, 0);
        for (int i = 0; i < 3; i++)
            vs_pulse(4, (i < 2) ? "sync_skip3" : "run_release3", (i < 2) ? 5 : 6, 0);

        // Asynchronous reset in the middle of SYNC
        do_restart();
        seq_to_cfgw(0);
        cfg_err = 1'b1;
        chk(1, "err_retry2", 0, 1);
        cfg_err = 1'b0;
        seq_to_cfgw(1);
        done_to_sync(1);
        vs_pulse(3, "sync_skip4", 5, 1);
        #2;
        rst_n = 1'b0;
        push("async_reset", sv(0, 0));
        #1;
        pop_check();
        chk(1, "reset_hold", 0, 0);
        rst_n = 1'b1;
        seq_to_cfgw(0);
        done_to_sync(0);
        for (int i = 0; i < 3; i++)
            vs_pulse(6, (i < 2) ? "sync_skip5" : "run_release5", (i < 2) ? 5 : 6, 0);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover: observed=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
